// File: rtl/semiauto_motion_driver_if.sv
// Signal bundle between the semi-auto decision FSM and its motion driver stage.
// The decision side is the master; the driver (with its H-bridge lines) is the slave.
interface semiauto_motion_driver_if #(
    parameter int PWM_BITS = 8
);
    logic                enable;
    logic [1:0]          next_state;
    logic [3:0]          next_moving_state;
    logic [1:0]          state;
    logic [3:0]          moving_state;
    logic                motor_l_fwd;
    logic                motor_l_rev;
    logic                motor_r_fwd;
    logic                motor_r_rev;
    logic [PWM_BITS-1:0] duty;
    logic                dead_busy;
    logic                illegal_cmd;

    modport master (
        output enable, next_state, next_moving_state,
        input  state, moving_state, motor_l_fwd, motor_l_rev, motor_r_fwd, motor_r_rev,
        input  duty, dead_busy, illegal_cmd
    );

    modport slave (
        input  enable, next_state, next_moving_state,
        output state, moving_state, motor_l_fwd, motor_l_rev, motor_r_fwd, motor_r_rev,
        output duty, dead_busy, illegal_cmd
    );
endinterface

// File: rtl/semiauto_motion_driver.sv
// Registers the decision FSM feedback and drives the H-bridge lines with PWM,
// soft-start ramping and a dead-time gap on every change of drive pattern.
module semiauto_motion_driver #(
    parameter int PWM_BITS    = 8,
    parameter int DUTY_MAX    = 255,
    parameter int RAMP_STEP   = 16,
    parameter int RAMP_DIV    = 50000,
    parameter int DEAD_CYCLES = 100000
) (
    input logic                     sys_clk,
    input logic                     rst_n,
    semiauto_motion_driver_if.slave bus
);
    typedef enum logic [1:0] {D_IDLE, D_RAMP, D_RUN, D_DEAD} drv_state_e;

    localparam logic [19:0]         RAMP_LAST  = 20'(RAMP_DIV - 1);
    localparam logic [19:0]         DEAD_LAST  = 20'(DEAD_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX_V = PWM_BITS'(DUTY_MAX);
    localparam logic [PWM_BITS-1:0] STEP_V     = PWM_BITS'(RAMP_STEP);

    logic [1:0]          state_q, state_d;
    logic [3:0]          ms_q, ms_d, prev_ms_q;
    drv_state_e          drv_q, drv_d;
    logic [3:0]          applied_q, applied_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [19:0]         ramp_cnt_q, ramp_cnt_d;
    logic [19:0]         dead_cnt_q, dead_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [3:0]          lines_q, lines_d;

    logic [3:0]          target;
    logic                cmd_illegal;
    logic                ramp_tick;
    logic                dead_done;
    logic [PWM_BITS:0]   duty_sum;
    logic [PWM_BITS-1:0] duty_inc;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= 2'b01;
            ms_q       <= 4'b0000;
            prev_ms_q  <= 4'b0000;
            drv_q      <= D_IDLE;
            applied_q  <= 4'b0000;
            duty_q     <= '0;
            ramp_cnt_q <= '0;
            dead_cnt_q <= '0;
            pwm_cnt_q  <= '0;
            lines_q    <= 4'b0000;
        end else begin
            state_q    <= state_d;
            ms_q       <= ms_d;
            prev_ms_q  <= ms_q;
            drv_q      <= drv_d;
            applied_q  <= applied_d;
            duty_q     <= duty_d;
            ramp_cnt_q <= ramp_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            lines_q    <= lines_d;
        end
    end

    // Disabling parks the decision FSM in its idle state with a stop command.
    always_comb begin
        state_d = bus.enable ? bus.next_state        : 2'b01;
        ms_d    = bus.enable ? bus.next_moving_state : 4'b0000;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        target      = 4'b0000;
        cmd_illegal = 1'b0;
        case (ms_q)
            4'b0000: target = 4'b0000;
            4'b0001: target = 4'b1010;
            4'b0010: target = 4'b0101;
            4'b0100: target = 4'b0110;
            4'b1000: target = 4'b1001;
            default: cmd_illegal = 1'b1;
        endcase
    end

    assign ramp_tick = (ramp_cnt_q == RAMP_LAST);
    assign dead_done = (dead_cnt_q == DEAD_LAST);

    always_comb begin
        duty_sum = {1'b0, duty_q} + {1'b0, STEP_V};
        duty_inc = (duty_sum >= {1'b0, DUTY_MAX_V}) ? DUTY_MAX_V : duty_sum[PWM_BITS-1:0];
    end

    always_comb begin
        drv_d = drv_q;
        case (drv_q)
            D_IDLE: if (target != 4'b0000) drv_d = D_RAMP;
            D_RAMP: begin
                if (target != applied_q)                    drv_d = D_DEAD;
                else if (ramp_tick && duty_inc == DUTY_MAX_V) drv_d = D_RUN;
            end
            D_RUN:  if (target != applied_q) drv_d = D_DEAD;
            D_DEAD: if (dead_done) drv_d = (target == 4'b0000) ? D_IDLE : D_RAMP;
            default: drv_d = D_IDLE;
        endcase
    end

    // Datapath follows the transition chosen above; lines use next values so they
    // always equal applied & gate of the same cycle, hence 0 whenever duty is 0.
    always_comb begin
        applied_d  = applied_q;
        duty_d     = duty_q;
        ramp_cnt_d = ramp_cnt_q;
        dead_cnt_d = dead_cnt_q;
        pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
        if (drv_d == D_DEAD) begin
            if (drv_q != D_DEAD) begin
                applied_d  = 4'b0000;
                duty_d     = '0;
                dead_cnt_d = '0;
            end else begin
                dead_cnt_d = dead_cnt_q + 20'd1;
            end
        end else if (drv_d == D_RAMP && drv_q != D_RAMP) begin
            applied_d  = target;
            duty_d     = STEP_V;
            ramp_cnt_d = '0;
        end else if (drv_q == D_RAMP) begin
            ramp_cnt_d = ramp_tick ? 20'd0 : ramp_cnt_q + 20'd1;
            if (ramp_tick) duty_d = duty_inc;
        end
        lines_d = applied_d & {4{pwm_cnt_d < duty_d}};
    end

    always_comb begin
        bus.state        = state_q;
        bus.moving_state = ms_q;
        bus.motor_l_fwd  = lines_q[3];
        bus.motor_l_rev  = lines_q[2];
        bus.motor_r_fwd  = lines_q[1];
        bus.motor_r_rev  = lines_q[0];
        bus.duty         = duty_q;
        bus.dead_busy    = (drv_q == D_DEAD);
        bus.illegal_cmd  = cmd_illegal && (ms_q != prev_ms_q);
    end
endmodule

// File: tb/tb_semiauto_motion_driver.sv
// Scoreboard bench: a time-based reference model queues the expected outputs of
// every cycle and a negedge monitor compares them against the driver.
module tb_semiauto_motion_driver;
    localparam int DEAD = 4;
    localparam int DIV  = 2;
    localparam int STEP = 64;
    localparam int MAX  = 255;

    typedef logic [31:0] snap_t;
    localparam snap_t RESET_SNAP = {12'd0, 2'b01, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0};

    logic sys_clk = 1'b0;
    logic rst_n, slow_rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    snap_t exp_q[$];

    always #5 sys_clk = ~sys_clk;

    semiauto_motion_driver_if #(.PWM_BITS(8)) bus ();
    semiauto_motion_driver_if #(.PWM_BITS(8)) s_bus ();

    semiauto_motion_driver #(
        .PWM_BITS(8), .DUTY_MAX(MAX), .RAMP_STEP(STEP), .RAMP_DIV(DIV), .DEAD_CYCLES(DEAD)
    ) u_dut (.sys_clk(sys_clk), .rst_n(rst_n), .bus(bus));

    // Slow-ramp copy holds duty at the first step long enough to measure a full PWM period.
    semiauto_motion_driver #(
        .PWM_BITS(8), .DUTY_MAX(MAX), .RAMP_STEP(STEP), .RAMP_DIV(1024), .DEAD_CYCLES(DEAD)
    ) u_slow (.sys_clk(sys_clk), .rst_n(slow_rst_n), .bus(s_bus));

    snap_t dut_snap;
    assign dut_snap = {12'd0, bus.state, bus.moving_state,
                       bus.motor_l_fwd, bus.motor_l_rev, bus.motor_r_fwd, bus.motor_r_rev,
                       bus.duty, bus.dead_busy, bus.illegal_cmd};

    task automatic check(input string name, input snap_t act, input snap_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: drive pattern table, a gap countdown, and duty as a function of
    // time since the ramp began.
    function automatic logic [3:0] pattern_of(input logic [3:0] c);
        case (c)
            4'b0001: return 4'b1010;
            4'b0010: return 4'b0101;
            4'b0100: return 4'b0110;
            4'b1000: return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    logic [1:0] m_state;
    logic [3:0] m_ms, m_prev_ms, m_applied;
    int         m_duty, m_pwm, m_dead_left, m_ramp_t;

    task automatic model_reset();
        m_state = 2'b01; m_ms = 4'b0000; m_prev_ms = 4'b0000; m_applied = 4'b0000;
        m_duty = 0; m_pwm = 0; m_dead_left = 0; m_ramp_t = 0;
    endtask

    task automatic model_step();
        logic [3:0] tgt, lines;
        logic       ill;
        tgt = pattern_of(m_ms);
        if (m_dead_left > 0) begin
            if (m_dead_left == 1) begin
                m_dead_left = 0;
                if (tgt != 4'b0000) begin m_applied = tgt; m_ramp_t = 0; m_duty = STEP; end
            end else begin
                m_dead_left--;
            end
        end else if (m_applied != 4'b0000) begin
            if (tgt != m_applied) begin
                m_dead_left = DEAD; m_applied = 4'b0000; m_duty = 0;
            end else begin
                m_ramp_t++;
                m_duty = STEP * (1 + m_ramp_t / DIV);
                if (m_duty > MAX) m_duty = MAX;
            end
        end else if (tgt != 4'b0000) begin
            m_applied = tgt; m_ramp_t = 0; m_duty = STEP;
        end
        m_pwm = (m_pwm + 1) % 256;
        lines = (m_pwm < m_duty) ? m_applied : 4'b0000;
        m_prev_ms = m_ms;
        m_ms      = bus.enable ? bus.next_moving_state : 4'b0000;
        m_state   = bus.enable ? bus.next_state : 2'b01;
        ill = !(m_ms inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000}) && (m_ms != m_prev_ms);
        exp_q.push_back({12'd0, m_state, m_ms, lines, 8'(m_duty), (m_dead_left > 0), ill});
    endtask

    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
            exp_q.delete();
        end else begin
            model_step();
        end
    end

    always @(negedge sys_clk) begin
        if (!rst_n) check("reset_outputs", dut_snap, RESET_SNAP);
        else if (exp_q.size() > 0) check("cycle", dut_snap, exp_q.pop_front());
    end

    task automatic run(input int n, output int busy_n, output int ill_n);
        busy_n = 0;
        ill_n  = 0;
        repeat (n) begin
            @(posedge sys_clk);
            #2;
            busy_n += int'(bus.dead_busy);
            ill_n  += int'(bus.illegal_cmd);
        end
    endtask

    task automatic cmd(input logic en, input logic [3:0] ms);
        bus.enable            = en;
        bus.next_moving_state = ms;
        bus.next_state        = 2'($urandom_range(0, 3));
    endtask

    int busy_n, ill_n, hi_n, rev_n;
    logic [3:0] cmds [5];

    initial begin
        cmds = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        rst_n = 1'b0; slow_rst_n = 1'b0;
        bus.enable = 1'b1; bus.next_state = 2'b10; bus.next_moving_state = 4'b0001;
        s_bus.enable = 1'b1; s_bus.next_state = 2'b00; s_bus.next_moving_state = 4'b0001;

        // PWM duty-cycle at the first ramp step, measured on the slow-ramp copy
        repeat (2) @(posedge sys_clk);
        #2 slow_rst_n = 1'b1;
        repeat (3) @(posedge sys_clk);
        #2 check("slow_duty", 32'(s_bus.duty), 32'd64);
        hi_n = 0; rev_n = 0;
        repeat (256) begin
            @(posedge sys_clk);
            #2;
            hi_n  += int'(s_bus.motor_l_fwd);
            rev_n += int'(s_bus.motor_l_rev) + int'(s_bus.motor_r_rev);
        end
        check("pwm_high_cycles", 32'(hi_n), 32'd64);
        check("rev_lines_idle", 32'(rev_n), 32'd0);

        // Reset held with a forward command waiting, then release
        check("reset_state", dut_snap, RESET_SNAP);
        rst_n = 1'b1;
        run(1, busy_n, ill_n);
        check("ms_after_release", 32'(bus.moving_state), 32'h1);
        run(13, busy_n, ill_n);
        check("fwd_no_gap", 32'(busy_n), 32'd0);
        check("fwd_run_duty", 32'(bus.duty), 32'd255);

        cmd(1'b1, 4'b0100);
        run(12, busy_n, ill_n);
        check("reversal_gap", 32'(busy_n), 32'd4);

        cmd(1'b1, 4'b0000);
        run(10, busy_n, ill_n);
        check("stop_gap", 32'(busy_n), 32'd4);
        cmd(1'b1, 4'b1000);
        run(12, busy_n, ill_n);
        check("start_from_stop_gap", 32'(busy_n), 32'd0);

        cmd(1'b1, 4'b0101);
        run(10, busy_n, ill_n);
        check("illegal_pulses", 32'(ill_n), 32'd1);
        check("illegal_as_stop", 32'(busy_n), 32'd4);

        cmd(1'b1, 4'b0001);
        run(4, busy_n, ill_n);
        cmd(1'b0, 4'b0001);
        run(1, busy_n, ill_n);
        check("disable_feedback", 32'({bus.state, bus.moving_state}), 32'h10);
        run(9, busy_n, ill_n);
        check("disable_gap", 32'(busy_n), 32'd4);

        // Asynchronous reset between edges while running
        cmd(1'b1, 4'b0001);
        run(14, busy_n, ill_n);
        check("pre_reset_duty", 32'(bus.duty), 32'd255);
        #1 rst_n = 1'b0;
        #1;
        check("async_lines", 32'({bus.motor_l_fwd, bus.motor_l_rev, bus.motor_r_fwd, bus.motor_r_rev}), 32'd0);
        check("async_duty", 32'(bus.duty), 32'd0);
        run(2, busy_n, ill_n);
        rst_n = 1'b1;

        // Randomized command sequences against the model
        for (int i = 0; i < 60; i++) begin
            int k;
            k = int'($urandom_range(0, 5));
            if (k == 5) cmd($urandom_range(0, 9) != 0, 4'($urandom_range(0, 15)));
            else        cmd($urandom_range(0, 9) != 0, cmds[k]);
            run(int'($urandom_range(1, 15)), busy_n, ill_n);
        end

        @(posedge sys_clk);
        @(negedge sys_clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/semiauto_motion_driver.md
Name: semiauto_motion_driver

Overview:
- Downstream stage of the semi-auto decision FSM. Registers that FSM's combinational next_state / next_moving_state into the state / moving_state feedback registers.
- Converts the registered motion command into four PWM-gated H-bridge drive lines.
- Applies soft-start ramping and a dead-time gap on every direction change, so the motors never see an instant reversal.

Parameters:
- PWM_BITS, 8, width of the duty value and of the free-running PWM counter.
- DUTY_MAX, 255, saturation value of duty.
- RAMP_STEP, 16, duty increment per ramp tick.
- RAMP_DIV, 50000, sys_clk cycles per ramp tick (legal range 1..2^20).
- DEAD_CYCLES, 100000, sys_clk cycles with all drive lines low between two different non-stop patterns (legal range 1..2^20).

Ports:
- sys_clk  in  1  system clock; the only clock in the block.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = power on and semi-auto/auto mode active.
- next_state  in  2  next FSM state from the decision block.
- next_moving_state  in  4  next motion command: 0000 stop, 0001 forward, 0010 reverse, 0100 left, 1000 right.
- state  out  2  registered FSM state, fed back to the decision block.
- moving_state  out  4  registered motion command, fed back to the decision block.
- motor_l_fwd  out  1  left wheel forward drive (PWM-gated).
- motor_l_rev  out  1  left wheel reverse drive.
- motor_r_fwd  out  1  right wheel forward drive.
- motor_r_rev  out  1  right wheel reverse drive.
- duty  out  PWM_BITS  current applied duty.
- dead_busy  out  1  high while in the dead-time gap.
- illegal_cmd  out  1  one-cycle pulse when a non-listed moving_state code is first decoded.

Behaviour:
- Reset (rst_n=0, asynchronous): state=01, moving_state=0000, all motor lines 0, duty=0, dead_busy=0, illegal_cmd=0, PWM counter=0, driver FSM in D_IDLE.
- Feedback registers:
  - Each cycle, with enable=1: state<=next_state and moving_state<=next_moving_state.
  - With enable=0: state<=01 and moving_state<=0000.
  - Latency: 1 cycle.
- Pattern decode from moving_state {l_fwd,l_rev,r_fwd,r_rev}:
  - 0001 -> 1010; 0010 -> 0101; 0100 -> 0110; 1000 -> 1001; 0000 -> 0000.
  - Any other code -> 0000, and illegal_cmd pulses on the first cycle it appears.
- PWM counter: free-running, increments every cycle, wraps from 2^PWM_BITS-1 to 0. gate = (pwm_cnt < duty).
- Drive lines: registered, equal to applied_pattern & {4{gate}}. Lines are 0 whenever duty=0.
- Driver FSM (applied = currently driven pattern; target = decoded pattern):
  - D_IDLE (applied=0000, duty=0): target≠0000 -> applied<=target, duty<=RAMP_STEP, ramp counter cleared, go D_RAMP. No dead time is needed from stop.
  - D_RAMP:
    - Every RAMP_DIV cycles, duty<=min(duty+RAMP_STEP, DUTY_MAX).
    - Reaching DUTY_MAX -> D_RUN.
    - target≠applied -> D_DEAD.
  - D_RUN: duty held. target≠applied -> D_DEAD.
  - D_DEAD:
    - On entry: applied<=0000, duty<=0, dead counter cleared, dead_busy=1.
    - After DEAD_CYCLES cycles: if target=0000 go D_IDLE; otherwise applied<=target, duty<=RAMP_STEP, go D_RAMP.
    - A target change during D_DEAD does not restart the counter; the latest target is used at expiry.
- Stop from D_RAMP/D_RUN goes through D_DEAD (lines drop immediately), then to D_IDLE.
- enable=0 forces moving_state=0000 on the next cycle, so the driver handles it as a normal stop.
- Width rules: duty add saturates. Ramp and dead counters are 20 bits, compared to parameter-1 for wrap.
- Mid-operation reset: everything returns to reset values immediately, with no glitch on the drive lines.

Test Plan:
All cases use DEAD_CYCLES=4, RAMP_DIV=2, RAMP_STEP=64, DUTY_MAX=255.
1. Reset and enable:
   - Stimulus: hold rst_n=0 with next_moving_state=0001.
   - Required: all outputs at reset values, state=01.
   - Then: release reset with enable=1 -> moving_state=0001 one cycle later.
2. Forward ramp:
   - Stimulus: command 0001 from idle.
   - Required: applied=1010 with no dead gap; duty steps 64,128,192,255 at 2-cycle intervals, then holds 255.
   - motor_l_fwd duty-cycle over 256 cycles at duty=64 must be exactly 64 high cycles; motor_l_rev and motor_r_rev stay 0.
3. Reversal:
   - Stimulus: change the command from 0001 (in D_RUN) to 0100.
   - Required: all lines 0 and dead_busy=1 for exactly 4 cycles, then pattern 0110 with duty=64.
4. Stop:
   - Stimulus: command 0000 from D_RUN.
   - Required: lines 0 next cycle, duty=0, dead_busy for 4 cycles, then D_IDLE.
   - Then: a new 1000 command ramps with no further gap.
5. Illegal code and enable:
   - Stimulus: moving_state 0101.
   - Required: illegal_cmd high for exactly one cycle, handled as stop.
   - Stimulus: enable=0 mid-ramp.
   - Required: state=01 and moving_state=0000 next cycle, then the dead/stop sequence.
6. Asynchronous reset mid-run:
   - Stimulus: assert rst_n between clock edges during D_RUN.
   - Required: drive lines and duty go to 0 before the next edge.
